board_lock_ctrl: RTL and testbench

- Owns the 10x20 fallen-blocks occupancy grid. Sequences the lifecycle of each landed piece: lock its four squares, scan for full rows, collapse cleared rows, report the result.
- Sits between the piece-movement logic, which issues lock requests, and the fallen-blocks renderer, which reads grid rows over a registered read port.
- Detects top-out and holds a game-over state until a new game is started.

---
 rtl/board_pkg.sv | 37 +++
 rtl/board_lock_ctrl_if.sv | 40 ++++
 rtl/board_row_file.sv | 63 ++++++
 rtl/board_lock_ctrl.sv | 140 ++++++++++++++
 tb/tb_board_lock_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// ============================================================================
// board_pkg: shared geometry, limits and FSM encoding for the lock controller
// Rev 1.0
// ============================================================================
`default_nettype none

package board_pkg;

    localparam int COLS       = 10;
    localparam int ROWS       = 20;
    localparam int SPAWN_ROWS = 2;

    localparam int COORD_W = 5;
    localparam int LINES_W = 3;
    localparam int TOTAL_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t COL_LIM   = coord_t'(COLS);
    localparam coord_t ROW_LIM   = coord_t'(ROWS);
    localparam coord_t SPAWN_LIM = coord_t'(SPAWN_ROWS);
    localparam coord_t LAST_ROW  = coord_t'(ROWS - 1);

    localparam logic [COLS-1:0] FULL_ROW = {COLS{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_SCAN  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/board_lock_ctrl_if.sv
// ============================================================================
// board_lock_ctrl_if: lock request, status and renderer read-port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface board_lock_ctrl_if;
    import board_pkg::*;

    logic                  new_game;
    logic                  lock_req;
    coord_t                sq_1_col, sq_2_col, sq_3_col, sq_4_col;
    coord_t                sq_1_row, sq_2_row, sq_3_row, sq_4_row;
    logic                  ready;
    logic                  lock_done;
    logic [LINES_W-1:0]    lines_cleared;
    logic [TOTAL_W-1:0]    total_lines;
    logic                  game_over;
    coord_t                rd_row;
    logic [COLS-1:0]       rd_data;

    modport master (
        output new_game, lock_req,
        output sq_1_col, sq_2_col, sq_3_col, sq_4_col,
        output sq_1_row, sq_2_row, sq_3_row, sq_4_row,
        output rd_row,
        input  ready, lock_done, lines_cleared, total_lines, game_over, rd_data
    );

    modport slave (
        input  new_game, lock_req,
        input  sq_1_col, sq_2_col, sq_3_col, sq_4_col,
        input  sq_1_row, sq_2_row, sq_3_row, sq_4_row,
        input  rd_row,
        output ready, lock_done, lines_cleared, total_lines, game_over, rd_data
    );

endinterface

`default_nettype wire

// File: rtl/board_row_file.sv
// ============================================================================
// board_row_file: ROWS x COLS occupancy grid with OR-write, shift-down and clear
// Rev 1.0
// ============================================================================
`default_nettype none

module board_row_file
    import board_pkg::*;
(
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             clr_i,
    input  wire logic             wr_en_i,
    input  wire coord_t [3:0]     sq_col_i,
    input  wire coord_t [3:0]     sq_row_i,
    input  wire logic             sh_en_i,
    input  wire coord_t           sh_row_i,
    input  wire coord_t           pk_row_i,
    output logic                  pk_full_o,
    input  wire coord_t           rd_row_i,
    output logic [COLS-1:0]       rd_data_o
);

    localparam logic [COLS-1:0] ONE_HOT0 = {{(COLS-1){1'b0}}, 1'b1};

    logic [COLS-1:0] grid_q [ROWS];
    logic [COLS-1:0] grid_d [ROWS];
    logic [COLS-1:0] rd_data_q;

    // Only one operation per cycle; clear outranks write outranks shift.
    always_comb begin
        grid_d = grid_q;
        if (clr_i) begin
            for (int r = 0; r < ROWS; r++) grid_d[r] = '0;
        end else if (wr_en_i) begin
            for (int k = 0; k < 4; k++) begin
                if (sq_col_i[k] < COL_LIM && sq_row_i[k] < ROW_LIM)
                    grid_d[sq_row_i[k]] = grid_d[sq_row_i[k]] | (ONE_HOT0 << sq_col_i[k]);
            end
        end else if (sh_en_i && sh_row_i < ROW_LIM) begin
            if (sh_row_i == '0)
                grid_d[0] = '0;
            else
                grid_d[sh_row_i] = grid_q[sh_row_i - coord_t'(1)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < ROWS; r++) grid_q[r] <= '0;
            rd_data_q <= '0;
        end else begin
            grid_q    <= grid_d;
            rd_data_q <= (rd_row_i < ROW_LIM) ? grid_q[rd_row_i] : '0;
        end
    end

    assign pk_full_o = (pk_row_i < ROW_LIM) && (grid_q[pk_row_i] == FULL_ROW);
    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/board_lock_ctrl.sv
// ============================================================================
// board_lock_ctrl: lock/scan/collapse sequencer, line counters and top-out
// Rev 1.0
// ============================================================================
`default_nettype none

module board_lock_ctrl
    import board_pkg::*;
(
    input  wire logic        pclk,
    input  wire logic        rst,
    board_lock_ctrl_if.slave bus
);

    state_t               state_q, state_d;
    coord_t               scan_q, scan_d;
    coord_t               shift_q, shift_d;
    coord_t [3:0]         cols_q, cols_d;
    coord_t [3:0]         rows_q, rows_d;
    logic [LINES_W-1:0]   lines_q, lines_d;
    logic [TOTAL_W-1:0]   total_q, total_d;

    logic clr, wr_en, sh_en, pk_full, topout;

    // Top-out only counts squares that actually land on the grid.
    always_comb begin
        topout = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (cols_q[k] < COL_LIM && rows_q[k] < ROW_LIM && rows_q[k] < SPAWN_LIM)
                topout = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        shift_d = shift_q;
        cols_d  = cols_q;
        rows_d  = rows_q;
        lines_d = lines_q;
        total_d = total_q;
        clr     = 1'b0;
        wr_en   = 1'b0;
        sh_en   = 1'b0;
        if (bus.new_game) begin
            clr     = 1'b1;
            state_d = ST_IDLE;
            lines_d = '0;
            total_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.lock_req) begin
                        cols_d  = {bus.sq_4_col, bus.sq_3_col, bus.sq_2_col, bus.sq_1_col};
                        rows_d  = {bus.sq_4_row, bus.sq_3_row, bus.sq_2_row, bus.sq_1_row};
                        lines_d = '0;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wr_en = 1'b1;
                    if (topout) begin
                        state_d = ST_OVER;
                    end else begin
                        scan_d  = LAST_ROW;
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (pk_full) begin
                        shift_d = scan_q;
                        state_d = ST_SHIFT;
                    end else if (scan_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        scan_d = scan_q - coord_t'(1);
                    end
                end
                ST_SHIFT: begin
                    sh_en = 1'b1;
                    if (shift_q == '0) begin
                        // scan_q is left alone so the row that just dropped in is re-checked.
                        lines_d = (lines_q == {LINES_W{1'b1}}) ? lines_q : lines_q + LINES_W'(1);
                        total_d = total_q + TOTAL_W'(1);
                        state_d = ST_SCAN;
                    end else begin
                        shift_d = shift_q - coord_t'(1);
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_OVER:  state_d = ST_OVER;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            scan_q  <= '0;
            shift_q <= '0;
            cols_q  <= '0;
            rows_q  <= '0;
            lines_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            shift_q <= shift_d;
            cols_q  <= cols_d;
            rows_q  <= rows_d;
            lines_q <= lines_d;
            total_q <= total_d;
        end
    end

    board_row_file u_rows (
        .clk_i     (pclk),
        .rst_i     (rst),
        .clr_i     (clr),
        .wr_en_i   (wr_en),
        .sq_col_i  (cols_q),
        .sq_row_i  (rows_q),
        .sh_en_i   (sh_en),
        .sh_row_i  (shift_q),
        .pk_row_i  (scan_q),
        .pk_full_o (pk_full),
        .rd_row_i  (bus.rd_row),
        .rd_data_o (bus.rd_data)
    );

    assign bus.ready         = (state_q == ST_IDLE);
    assign bus.lock_done     = (state_q == ST_DONE);
    assign bus.game_over     = (state_q == ST_OVER);
    assign bus.lines_cleared = lines_q;
    assign bus.total_lines   = total_q;

endmodule

`default_nettype wire

// File: tb/tb_board_lock_ctrl.sv
// ============================================================================
// tb_board_lock_ctrl: scoreboard bench with a row-list reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_board_lock_ctrl;
    import board_pkg::*;

    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    board_lock_ctrl_if bif ();

    board_lock_ctrl dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bif)
    );

    typedef struct {
        int lines;
        int total;
        int done_cyc;
    } exp_t;

    exp_t            q[$];
    exp_t            mon_e;
    int              total_cmp = 0;
    int              bad = 0;
    int              cyc = 0;
    logic [COLS-1:0] m_grid [ROWS];
    int              m_total = 0;
    int              sc[4];
    int              sr[4];

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cmp++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every lock_done pulse must match the oldest pending expectation.
    always @(negedge pclk) begin
        if (rst === 1'b0 && bif.lock_done === 1'b1) begin
            if (q.size() == 0) begin
                total_cmp++;
                bad++;
                $display("FAIL unexpected_lock_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("lines_cleared", 32'(bif.lines_cleared), 32'(mon_e.lines));
                chk("total_lines",   32'(bif.total_lines),   32'(mon_e.total));
                chk("done_cycle",    32'(cyc),               32'(mon_e.done_cyc));
            end
        end
    end

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++) m_grid[r] = '0;
        m_total = 0;
        q.delete();
    endtask

    // Reference: drop squares, then rebuild the board from the surviving rows.
    // A full row originally at r with k full rows beneath it is cleared while
    // sitting at row r+k, costing (r+k+1) shift cycles plus one re-scan.
    task automatic model_lock(output bit topout, output int lines, output int lat);
        logic [COLS-1:0] kept[$];
        int k;
        topout = 0;
        lines  = 0;
        lat    = ROWS + 1;
        for (int i = 0; i < 4; i++) begin
            if (sc[i] < COLS && sr[i] < ROWS) begin
                m_grid[sr[i]][sc[i]] = 1'b1;
                if (sr[i] < SPAWN_ROWS) topout = 1;
            end
        end
        if (topout) return;
        k = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (m_grid[r] == {COLS{1'b1}}) begin
                lat += r + k + 2;
                k++;
            end else begin
                kept.push_back(m_grid[r]);
            end
        end
        for (int r = ROWS - 1; r >= 0; r--)
            m_grid[r] = (ROWS - 1 - r < kept.size()) ? kept[ROWS - 1 - r] : '0;
        lines   = (k > 7) ? 7 : k;
        m_total = (m_total + k) % 1024;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 400 && bif.ready !== 1'b1; i++) @(negedge pclk);
        if (bif.ready !== 1'b1) begin
            total_cmp++;
            bad++;
            $display("FAIL %s_ready_timeout actual=0 required=1", name);
        end
    endtask

    task automatic set_sq(input int c0, r0, c1, r1, c2, r2, c3, r3);
        sc[0] = c0; sr[0] = r0; sc[1] = c1; sr[1] = r1;
        sc[2] = c2; sr[2] = r2; sc[3] = c3; sr[3] = r3;
    endtask

    task automatic drive_sq();
        bif.sq_1_col = 5'(sc[0]); bif.sq_1_row = 5'(sr[0]);
        bif.sq_2_col = 5'(sc[1]); bif.sq_2_row = 5'(sr[1]);
        bif.sq_3_col = 5'(sc[2]); bif.sq_3_row = 5'(sr[2]);
        bif.sq_4_col = 5'(sc[3]); bif.sq_4_row = 5'(sr[3]);
    endtask

    // Issues one lock; returns at a negedge with the DUT idle again (or in OVER).
    task automatic do_lock(output bit topout);
        int ln, lat, n;
        exp_t e;
        wait_ready("lock");
        drive_sq();
        bif.lock_req = 1'b1;
        n = cyc + 1;
        model_lock(topout, ln, lat);
        if (!topout) begin
            e.lines = ln; e.total = m_total; e.done_cyc = n + lat;
            q.push_back(e);
        end
        @(negedge pclk);
        bif.lock_req = 1'b0;
        if (!topout) wait_ready("done");
        else @(negedge pclk);
    endtask

    task automatic check_grid(input string tag);
        for (int r = 0; r < ROWS + 2; r++) begin
            bif.rd_row = 5'(r);
            @(negedge pclk);
            chk($sformatf("%s_row%0d", tag, r), 32'(bif.rd_data),
                32'((r < ROWS) ? m_grid[r] : '0));
        end
        chk({tag, "_total"}, 32'(bif.total_lines), 32'(m_total));
    endtask

    task automatic pulse_new_game();
        bif.new_game = 1'b1;
        @(negedge pclk);
        bif.new_game = 1'b0;
        model_clear();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit to;
        rst = 1'b1;
        bif.new_game = 1'b0;
        bif.lock_req = 1'b0;
        bif.rd_row   = '0;
        set_sq(0, 0, 0, 0, 0, 0, 0, 0);
        drive_sq();
        for (int r = 0; r < ROWS; r++) m_grid[r] = '0;
        repeat (3) @(negedge pclk);
        rst = 1'b0;

        chk("rst_ready",     32'(bif.ready), 1);
        chk("rst_lock_done", 32'(bif.lock_done), 0);
        chk("rst_lines",     32'(bif.lines_cleared), 0);
        chk("rst_total",     32'(bif.total_lines), 0);
        chk("rst_game_over", 32'(bif.game_over), 0);
        chk("rst_rd_data",   32'(bif.rd_data), 0);

        // Single lock on the floor, no clear: minimum latency.
        set_sq(0, 19, 1, 19, 2, 19, 3, 19);
        do_lock(to);
        check_grid("floor");

        // Complete row 19 with content above it in row 18.
        set_sq(4, 19, 5, 19, 0, 18, 2, 18);
        do_lock(to);
        set_sq(6, 19, 7, 19, 8, 19, 9, 19);
        do_lock(to);
        check_grid("one_line");

        // Four full rows cleared by a vertical I-piece.
        pulse_new_game();
        for (int r = 16; r < 20; r++) begin
            set_sq(0, r, 1, r, 2, r, 3, r); do_lock(to);
            set_sq(4, r, 5, r, 6, r, 7, r); do_lock(to);
        end
        set_sq(8, 16, 8, 17, 8, 18, 8, 19);
        do_lock(to);
        set_sq(9, 16, 9, 17, 9, 18, 9, 19);
        do_lock(to);
        check_grid("tetris");

        // Out-of-range squares are silently dropped.
        set_sq(12, 19, 0, 25, 3, 17, 4, 17);
        do_lock(to);
        check_grid("range");

        // Randomized locks around the bottom of the board.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                sc[i] = int'($urandom_range(0, 11));
                sr[i] = int'($urandom_range(15, 21));
            end
            do_lock(to);
            if (n % 10 == 9) check_grid("rand");
        end

        // Top-out: grid still written, later lock_req ignored.
        set_sq(4, 1, 5, 1, 4, 2, 5, 2);
        do_lock(to);
        chk("over_topout_model", 32'(to), 1);
        chk("over_game_over", 32'(bif.game_over), 1);
        chk("over_ready",     32'(bif.ready), 0);
        set_sq(0, 10, 1, 10, 2, 10, 3, 10);
        drive_sq();
        bif.lock_req = 1'b1;
        @(negedge pclk);
        bif.lock_req = 1'b0;
        repeat (30) @(negedge pclk);
        chk("over_hold", 32'(bif.game_over), 1);
        check_grid("over");
        pulse_new_game();
        chk("ng_game_over", 32'(bif.game_over), 0);
        chk("ng_ready",     32'(bif.ready), 1);
        chk("ng_lines",     32'(bif.lines_cleared), 0);
        check_grid("ng");

        // Reset in the middle of a collapse.
        set_sq(0, 19, 1, 19, 2, 19, 3, 19); do_lock(to);
        set_sq(4, 19, 5, 19, 6, 19, 7, 18); do_lock(to);
        wait_ready("mid");
        set_sq(7, 19, 8, 19, 9, 19, 9, 18);
        drive_sq();
        bif.lock_req = 1'b1;
        @(negedge pclk);
        bif.lock_req = 1'b0;
        repeat (5) @(negedge pclk);
        rst = 1'b1;
        model_clear();
        @(negedge pclk);
        rst = 1'b0;
        chk("rst_mid_ready", 32'(bif.ready), 1);
        chk("rst_mid_lines", 32'(bif.lines_cleared), 0);
        repeat (40) @(negedge pclk);
        check_grid("rst_mid");

        // new_game and lock_req together: lock dropped.
        set_sq(0, 19, 1, 19, 2, 19, 3, 19); do_lock(to);
        wait_ready("ng_lock");
        set_sq(5, 19, 6, 19, 7, 19, 8, 19);
        drive_sq();
        bif.lock_req = 1'b1;
        pulse_new_game();
        bif.lock_req = 1'b0;
        chk("ng_lock_ready", 32'(bif.ready), 1);
        repeat (40) @(negedge pclk);
        check_grid("ng_lock");
        chk("ng_lock_queue", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total_cmp, bad);
        $finish;
    end

endmodule

`default_nettype wire
